// File: rtl/cordic_iter.sv
// cordic_iter -- iterative CORDIC engine, rotation and vectoring modes.
//
// Rotation  (mode=0): in_a = angle (rad)  -> out_a = cos, out_b = sin
// Vectoring (mode=1): in_a = x, in_b = y  -> out_a = magnitude, out_b = angle
// All I/O words are signed Q(WIDTH-FRAC).FRAC.
//
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (mode, in_a, in_b sampled here)
//   out_valid / out_ready   result handshake (out_a, out_b held until taken)
//
// Sequence: IDLE -> REDUCE (1 + number of 2pi corrections) -> ITER (ITER
// cycles) -> SCALE -> DONE (waits for out_ready) -> IDLE.
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 13,
  parameter int ITER  = 13
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_a,
  output logic signed [WIDTH-1:0] out_b
);

  localparam int XW = WIDTH + 2;   // x/y: headroom for CORDIC gain and negation
  localparam int ZW = WIDTH + 3;   // z: must hold 2pi
  localparam int PW = 2 * XW;      // multiplier product / saturation input
  localparam int SH = 30 - FRAC;   // constants are stored scaled by 2^30
  localparam int CW = 5;

  // Rounded right shift of a 2^30-scaled constant down to FRAC bits.
  function automatic logic signed [ZW-1:0] rnd_const(input logic [63:0] v);
    logic [63:0] r;
    if (SH > 0) r = (v + (64'd1 << (SH - 1))) >> SH;
    else        r = v;
    return ZW'(r);
  endfunction

  // Clamp to the signed WIDTH-bit range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [WIDTH-1:0] r;
    if (!v[PW-1] && (|v[PW-2:WIDTH-1]))       r = {1'b0, {(WIDTH-1){1'b1}}};
    else if (v[PW-1] && !(&v[PW-2:WIDTH-1]))  r = {1'b1, {(WIDTH-1){1'b0}}};
    else                                      r = v[WIDTH-1:0];
    return r;
  endfunction

  function automatic logic signed [PW-1:0] ext_x(input logic signed [XW-1:0] v);
    return {{(PW-XW){v[XW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] ext_z(input logic signed [ZW-1:0] v);
    return {{(PW-ZW){v[ZW-1]}}, v};
  endfunction

  // atan(2^-i) * 2^30, i = 0..15
  localparam logic [31:0] ATAN_RAW [16] = '{
    32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
    32'd67021687,  32'd33543516,  32'd16775851,  32'd8388437,
    32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
    32'd262144,    32'd131072,    32'd65536,     32'd32768
  };

  localparam logic signed [ZW-1:0] PI_C      = rnd_const(64'd3373259426);
  localparam logic signed [ZW-1:0] TWO_PI_C  = rnd_const(64'd6746518852);
  localparam logic signed [ZW-1:0] HALF_PI_C = rnd_const(64'd1686629713);
  localparam logic signed [XW-1:0] K_X       = XW'(rnd_const(64'd652032874));

  logic signed [ZW-1:0] atan_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_atan
    assign atan_tab[g] = rnd_const({32'd0, ATAN_RAW[g]});
  end

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_ITER, S_SCALE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 flip_q, flip_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_a_q, out_a_d;
  logic signed [WIDTH-1:0] out_b_q, out_b_d;

  logic                 d_pos;
  logic signed [XW-1:0] x_sh, y_sh, xs, ys;
  logic signed [PW-1:0] prod, prod_sh;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    flip_d      = flip_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    d_pos       = 1'b0;
    x_sh        = '0;
    y_sh        = '0;
    xs          = '0;
    ys          = '0;
    prod        = '0;
    prod_sh     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mode_d     = mode;
          x_d        = {{2{in_a[WIDTH-1]}}, in_a};
          y_d        = {{2{in_b[WIDTH-1]}}, in_b};
          z_d        = {{3{in_a[WIDTH-1]}}, in_a};
          flip_d     = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_REDUCE;
        end
      end

      S_REDUCE: begin
        if (!mode_q) begin
          // One 2pi correction per cycle; once in [-pi, pi] fold into
          // [-pi/2, pi/2] (CORDIC convergence range) and remember to negate.
          if (z_q > PI_C) begin
            z_d = z_q - TWO_PI_C;
          end else if (z_q < -PI_C) begin
            z_d = z_q + TWO_PI_C;
          end else begin
            if (z_q > HALF_PI_C) begin
              z_d    = z_q - PI_C;
              flip_d = 1'b1;
            end else if (z_q < -HALF_PI_C) begin
              z_d    = z_q + PI_C;
              flip_d = 1'b1;
            end
            x_d     = K_X;
            y_d     = '0;
            cnt_d   = '0;
            state_d = S_ITER;
          end
        end else begin
          // Left half-plane: rotate by pi so x >= 0; the sign of the
          // original y picks which way round pi is pre-loaded.
          if (x_q[XW-1]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = y_q[XW-1] ? -PI_C : PI_C;
          end else begin
            z_d = '0;
          end
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        d_pos = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
        x_sh  = x_q >>> cnt_q;
        y_sh  = y_q >>> cnt_q;
        if (d_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_tab[cnt_q[3:0]];
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_tab[cnt_q[3:0]];
        end
        if (cnt_q == CW'(ITER - 1)) state_d = S_SCALE;
        else                        cnt_d   = cnt_q + 1'b1;
      end

      S_SCALE: begin
        if (!mode_q) begin
          xs      = flip_q ? -x_q : x_q;
          ys      = flip_q ? -y_q : y_q;
          out_a_d = sat(ext_x(xs));
          out_b_d = sat(ext_x(ys));
        end else begin
          // Remove the CORDIC gain; product is truncated, not rounded.
          prod    = x_q * K_X;
          prod_sh = prod >>> FRAC;
          out_a_d = sat(prod_sh);
          out_b_d = sat(ext_z(z_q));
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      flip_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      flip_q      <= flip_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter -- directed bench for cordic_iter with default parameters
// (WIDTH=16, FRAC=13, ITER=13). Expected values are hand-computed
// trigonometry in Q3.13; numeric results are accepted within 4 LSB.
module tb_cordic_iter;

  logic               sys_clk   = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic               mode      = 1'b0;
  logic signed [15:0] in_a      = '0;
  logic signed [15:0] in_b      = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_a;
  logic signed [15:0] out_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  cordic_iter #(.WIDTH(16), .FRAC(13), .ITER(13)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [31:0] obs,
                           input int exp, input int tol);
    int diff;
    diff = int'(obs) - exp;
    n_checks++;
    assert ((diff <= tol) && (diff >= -tol)) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      $error("check %s", tag);
    end
  endtask

  // One operation: handshake, latency count (cycles after the handshake
  // cycle until out_valid), result check, and output handshake if
  // out_ready is high.
  task automatic run_op(input string tag, input logic m, input int a, input int b,
                        input int ea, input int ta, input int eb, input int tb,
                        input int lat);
    int k;
    @(negedge sys_clk);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    mode     = m;
    in_a     = a[15:0];
    in_b     = b[15:0];
    in_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
    mode     = ~m;            // operands after the handshake must be ignored
    in_a     = 16'sh1234;
    in_b     = -16'sh0777;
    check_eq({tag, "_in_ready_busy"}, in_ready, 0);
    k = 1;
    while (out_valid !== 1'b1 && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    check_eq({tag, "_latency"}, k, lat);
    check_tol({tag, "_out_a"}, out_a, ea, ta);
    check_tol({tag, "_out_b"}, out_b, eb, tb);
    if (out_ready) begin
      @(negedge sys_clk);
      check_eq({tag, "_out_valid_after_hs"}, out_valid, 0);
      check_eq({tag, "_in_ready_after_hs"}, in_ready, 1);
    end
  endtask

  initial begin
    // reset state
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_a", out_a, 0);
    check_eq("rst_out_b", out_b, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid_rel", out_valid, 0);

    // rotation
    run_op("rot_0",       1'b0, 0,      0, 8192, 4,     0, 4, 16);
    run_op("rot_pi2",     1'b0, 12868,  0,    0, 4,  8192, 4, 16);
    run_op("rot_m3pi4",   1'b0, -19302, 0, -5793, 4, -5793, 4, 16);
    run_op("rot_3p9",     1'b0, 31949,  0, -5946, 4, -5635, 4, 17);

    // vectoring
    run_op("vec_q2",      1'b1, -4096, 4096, 5793, 4, 19302, 4, 16);
    run_op("vec_sat",     1'b1, -32768, -32768, 32767, 0, -19302, 4, 16);

    // backpressure: result must hold, new operands ignored
    out_ready = 1'b0;
    run_op("bp", 1'b0, 0, 0, 8192, 4, 0, 4, 16);
    in_valid = 1'b1;
    mode     = 1'b1;
    in_a     = 16'sh0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_tol("bp_out_a", out_a, 8192, 4);
      check_tol("bp_out_b", out_b, 0, 4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clk);
    check_eq("bp_rel_out_valid", out_valid, 0);
    check_eq("bp_rel_in_ready", in_ready, 1);

    // reset during ITER
    @(negedge sys_clk);
    mode     = 1'b0;
    in_a     = 16'sh3244;
    in_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_a", out_a, 0);
    check_eq("mid_rst_out_b", out_b, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_eq("mid_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      check_eq("mid_rst_no_result", out_valid, 0);
    end

    // engine still usable afterwards
    run_op("post_rst", 1'b0, 12868, 0, 0, 4, 8192, 4, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
